// File: rtl/gray_counter_param.sv
`default_nettype none
// ============================================================================
// Module   : gray_counter_param
// Brief    : WIDTH-bit up/down Gray counter with load, wrap/saturate, binary
//            mirror, terminal-count and wrap-pulse outputs.
// Revision : 1.0 - initial release
// ============================================================================
module gray_counter_param #(
  parameter int unsigned      WIDTH      = 4,
  parameter int unsigned      SATURATE   = 0,
  parameter logic [WIDTH-1:0] RESET_GRAY = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] gray_q,
  output logic [WIDTH-1:0] bin_q,
  output logic             tc,
  output logic             wrap
);

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  localparam logic [WIDTH-1:0] c_MAX       = '1;
  localparam logic [WIDTH-1:0] c_ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_RESET_BIN = gray2bin(RESET_GRAY);
  localparam bit               c_SAT       = (SATURATE != 0);

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("gray_counter_param: WIDTH must lie in 2..16");
  end

  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gray_d;
  logic             wrap_d;

  // tc doubles as the "next step leaves the range" indicator.
  assign tc = up ? (bin_q == c_MAX) : (bin_q == '0);

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (load) begin
      bin_d = gray2bin(load_val);
    end else if (en) begin
      if (!tc) begin
        bin_d = up ? (bin_q + c_ONE) : (bin_q - c_ONE);
      end else if (!c_SAT) begin
        bin_d  = up ? '0 : c_MAX;
        wrap_d = 1'b1;
      end
    end
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_q <= RESET_GRAY;
      bin_q  <= c_RESET_BIN;
      wrap   <= 1'b0;
    end else begin
      gray_q <= gray_d;
      bin_q  <= bin_d;
      wrap   <= wrap_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gray_counter_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_counter_param
// Brief    : Self-checking bench for gray_counter_param (vectors, directed
//            corner cases, random stimulus against an arithmetic model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gray_counter_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, up, load;
  logic [3:0] lv;
  logic [3:0] a_g, a_b, b_g, b_b;
  logic       a_tc, a_wr, b_tc, b_wr;

  logic        s_en, s_up, s_load;
  logic [1:0]  lv2,  s2_g,  s2_b;
  logic [7:0]  lv8,  s8_g,  s8_b;
  logic [15:0] lv16, s16_g, s16_b;
  logic        s2_tc, s2_wr, s8_tc, s8_wr, s16_tc, s16_wr;

  gray_counter_param #(.WIDTH(4), .SATURATE(0), .RESET_GRAY(4'b0000)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(lv),
    .gray_q(a_g), .bin_q(a_b), .tc(a_tc), .wrap(a_wr));

  gray_counter_param #(.WIDTH(4), .SATURATE(1), .RESET_GRAY(4'b0110)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(lv),
    .gray_q(b_g), .bin_q(b_b), .tc(b_tc), .wrap(b_wr));

  gray_counter_param #(.WIDTH(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .en(s_en), .up(s_up), .load(s_load), .load_val(lv2),
    .gray_q(s2_g), .bin_q(s2_b), .tc(s2_tc), .wrap(s2_wr));

  gray_counter_param #(.WIDTH(8)) u_s8 (
    .clk(clk), .rst_n(rst_n), .en(s_en), .up(s_up), .load(s_load), .load_val(lv8),
    .gray_q(s8_g), .bin_q(s8_b), .tc(s8_tc), .wrap(s8_wr));

  gray_counter_param #(.WIDTH(16)) u_s16 (
    .clk(clk), .rst_n(rst_n), .en(s_en), .up(s_up), .load(s_load), .load_val(lv16),
    .gray_q(s16_g), .bin_q(s16_b), .tc(s16_tc), .wrap(s16_wr));

  int n_tests = 0;
  int n_fail  = 0;
  bit seen [3][65536];

  typedef struct {
    bit         ld;
    bit         e;
    bit         u;
    logic [3:0] lv;
    logic [3:0] g;
    logic [3:0] b;
    bit         wr;
    bit         tc;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int b2g(input int n);
    return n ^ (n >> 1);
  endfunction

  function automatic int g2b(input int g);
    int b = 0;
    for (int s = 0; s < 32; s++) b ^= (g >> s);
    return b;
  endfunction

  // Reference: step the integer position and fold out-of-range results.
  task automatic model(inout int n, output int wr, input bit ld, input int lvv,
                       input bit e, input bit u, input bit sat, input int w);
    int m, nx;
    m  = 1 << w;
    wr = 0;
    if (ld) n = g2b(lvv);
    else if (e) begin
      nx = u ? n + 1 : n - 1;
      if (nx < 0 || nx >= m) begin
        if (!sat) begin
          n  = (nx + m) % m;
          wr = 1;
        end
      end else n = nx;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic sweep_chk(input int k, input int w, input int e, input int g,
                           input int bn, input int wr, input int pg);
    int n;
    n = e % (1 << w);
    chk($sformatf("sweep w%0d e%0d gray", w, e), g, b2g(n));
    chk($sformatf("sweep w%0d e%0d bin", w, e), bn, n);
    chk($sformatf("sweep w%0d e%0d hamming", w, e), $countones(g ^ pg), 1);
    chk($sformatf("sweep w%0d e%0d wrap", w, e), wr, (n == 0) ? 1 : 0);
    if (e <= (1 << w)) begin
      chk($sformatf("sweep w%0d e%0d revisit", w, e), seen[k][g & 16'hFFFF], 0);
      seen[k][g & 16'hFFFF] = 1'b1;
    end
  endtask

  initial begin
    int ma, mb, wa, wb, n, pg [3];
    logic [3:0] prev;

    tbl[0]  = '{0, 1, 0, 4'b0000, 4'b1000, 4'd15, 1, 0};
    tbl[1]  = '{0, 0, 0, 4'b0000, 4'b1000, 4'd15, 0, 0};
    tbl[2]  = '{1, 1, 1, 4'b1101, 4'b1101, 4'd9,  0, 0};
    tbl[3]  = '{0, 1, 1, 4'b0000, 4'b1111, 4'd10, 0, 0};
    tbl[4]  = '{0, 0, 1, 4'b0000, 4'b1111, 4'd10, 0, 0};
    tbl[5]  = '{1, 0, 1, 4'b1000, 4'b1000, 4'd15, 0, 1};
    tbl[6]  = '{0, 1, 1, 4'b0000, 4'b0000, 4'd0,  1, 0};
    tbl[7]  = '{0, 0, 0, 4'b0000, 4'b0000, 4'd0,  0, 1};
    tbl[8]  = '{0, 1, 0, 4'b0000, 4'b1000, 4'd15, 1, 0};
    tbl[9]  = '{0, 1, 0, 4'b0000, 4'b1001, 4'd14, 0, 0};
    tbl[10] = '{0, 1, 1, 4'b0000, 4'b1000, 4'd15, 0, 1};

    en = 0; up = 1; load = 0; lv = '0;
    s_en = 0; s_up = 1; s_load = 0; lv2 = '0; lv8 = '0; lv16 = '0;
    do_reset();

    chk("reset a gray", a_g, 0);
    chk("reset a bin", a_b, 0);
    chk("reset a wrap", a_wr, 0);
    chk("reset b gray", b_g, 4'b0110);
    chk("reset b bin", b_b, 4);

    for (int i = 0; i < 11; i++) begin
      load = tbl[i].ld; en = tbl[i].e; up = tbl[i].u; lv = tbl[i].lv;
      tick();
      chk($sformatf("vec%0d gray", i), a_g, tbl[i].g);
      chk($sformatf("vec%0d bin", i), a_b, tbl[i].b);
      chk($sformatf("vec%0d wrap", i), a_wr, tbl[i].wr);
      chk($sformatf("vec%0d tc", i), a_tc, tbl[i].tc);
    end

    // Full up-count cycle from reset.
    en = 0; load = 0; up = 1;
    do_reset();
    en = 1;
    prev = a_g;
    for (int i = 1; i <= 16; i++) begin
      tick();
      n = i % 16;
      chk($sformatf("upcnt%0d gray", i), a_g, b2g(n));
      chk($sformatf("upcnt%0d hamming", i), $countones(a_g ^ prev), 1);
      chk($sformatf("upcnt%0d wrap", i), a_wr, (i == 16) ? 1 : 0);
      chk($sformatf("upcnt%0d tc", i), a_tc, (n == 15) ? 1 : 0);
      prev = a_g;
    end

    // Random stimulus on wrap and saturate instances.
    en = 0;
    do_reset();
    ma = 0; mb = 4;
    for (int i = 0; i < 400; i++) begin
      load = ($urandom_range(0, 7) == 0);
      en   = ($urandom_range(0, 3) != 0);
      up   = $urandom_range(0, 1);
      lv   = 4'($urandom);
      tick();
      model(ma, wa, load, int'(lv), en, up, 1'b0, 4);
      model(mb, wb, load, int'(lv), en, up, 1'b1, 4);
      chk($sformatf("rnd%0d a gray", i), a_g, b2g(ma));
      chk($sformatf("rnd%0d a bin", i), a_b, ma);
      chk($sformatf("rnd%0d a wrap", i), a_wr, wa);
      chk($sformatf("rnd%0d a tc", i), a_tc, (up ? ma == 15 : ma == 0) ? 1 : 0);
      chk($sformatf("rnd%0d b gray", i), b_g, b2g(mb));
      chk($sformatf("rnd%0d b bin", i), b_b, mb);
      chk($sformatf("rnd%0d b wrap", i), b_wr, wb);
      chk($sformatf("rnd%0d b tc", i), b_tc, (up ? mb == 15 : mb == 0) ? 1 : 0);
    end

    // Saturation at the top, then reversal.
    load = 1; en = 0; up = 1; lv = 4'b1000;
    tick();
    load = 0; en = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("sat%0d gray", i), b_g, 4'b1000);
      chk($sformatf("sat%0d wrap", i), b_wr, 0);
      chk($sformatf("sat%0d tc", i), b_tc, 1);
    end
    up = 0;
    tick();
    chk("sat rev gray", b_g, 4'b1001);
    chk("sat rev bin", b_b, 14);
    chk("sat rev tc", b_tc, 0);

    // Asynchronous reset between clock edges.
    load = 1; lv = 4'b0000; up = 1;
    tick();
    load = 0;
    repeat (3) tick();
    chk("pre-rst b bin", b_b, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst b gray", b_g, 4'b0110);
    chk("async rst b bin", b_b, 4);
    chk("async rst a gray", a_g, 0);
    tick();
    chk("rst held b bin", b_b, 4);
    rst_n = 1'b1;
    tick();
    chk("post-rst b bin", b_b, 5);
    chk("post-rst b gray", b_g, 4'b0111);

    // Width sweep.
    en = 0;
    do_reset();
    pg[0] = 0; pg[1] = 0; pg[2] = 0;
    s_en = 1;
    for (int e = 1; e <= 65537; e++) begin
      tick();
      sweep_chk(0, 2,  e, int'(s2_g),  int'(s2_b),  int'(s2_wr),  pg[0]);
      sweep_chk(1, 8,  e, int'(s8_g),  int'(s8_b),  int'(s8_wr),  pg[1]);
      sweep_chk(2, 16, e, int'(s16_g), int'(s16_b), int'(s16_wr), pg[2]);
      pg[0] = int'(s2_g); pg[1] = int'(s8_g); pg[2] = int'(s16_g);
    end
    s_en = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gray_counter_param.md
Name: gray_counter_param

Overview:
- Parametrised N-bit Gray-code counter; successor to the fixed 4-bit up-only Gray counter.
- Adds up/down counting, count enable, synchronous Gray-coded load, asynchronous active-low reset, wrap or saturate mode, a binary mirror output and terminal-count and wrap flags.
- Used for pointer generation (FIFO/CDC) and position encoders, where only one bit may change per count step.

Parameters:
- WIDTH, 4: counter width in bits, legal range 2..16.
- SATURATE, 0: 0 = wrap at the ends of the range; 1 = hold at all-max or zero.
- RESET_GRAY, 0: Gray-coded reset value of gray_q, WIDTH bits.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset; release is synchronous to clk.
- en  in  1  count enable, sampled on posedge.
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  synchronous load strobe; takes priority over en.
- load_val  in  WIDTH  Gray-coded value to load.
- gray_q  out  WIDTH  registered Gray count.
- bin_q  out  WIDTH  registered binary equivalent of gray_q.
- tc  out  1  combinational terminal count: (up and bin_q == 2^WIDTH-1) or (!up and bin_q == 0).
- wrap  out  1  registered one-cycle pulse; WIDTH-bit wrap event occurred on the previous edge.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - gray_q = RESET_GRAY.
  - bin_q = gray2bin(RESET_GRAY).
  - wrap = 0.
  - Reset applies immediately, including mid-count or mid-load. The first count occurs on the first posedge with rst_n = 1 and en = 1.
- State: a binary register b plus a registered Gray output. Both update on the same edge, so gray_q == b ^ (b >> 1) at all times. Outputs are glitch-free because they are taken straight from flops.
- Priority on each posedge: load, then en, then hold.
  - load = 1: b <= gray2bin(load_val), where bit i is the XOR of load_val[WIDTH-1:i]. gray_q <= load_val. wrap <= 0. en and up are ignored.
  - load = 0, en = 1, up = 1: b <= b + 1, modulo 2^WIDTH.
  - load = 0, en = 1, up = 0: b <= b - 1, modulo 2^WIDTH.
  - load = 0, en = 0: hold. wrap <= 0.
- Wrap mode (SATURATE = 0):
  - At b = max with up = 1, or b = 0 with up = 0, while en = 1: the count rolls over and wrap <= 1 for exactly one cycle.
  - Latency from the enabled edge to the wrap pulse is 1 cycle; wrap is high during the cycle in which the new value is visible.
- Saturate mode (SATURATE = 1):
  - At the same boundary conditions the counter holds its value and wrap stays 0.
  - tc remains asserted while the counter sits at the boundary and up points outward.
- Every en-driven step changes exactly one bit of gray_q, including the wrap step (max <-> 0). Load may change any number of bits.
- A direction change takes effect on the edge where the new up value is sampled. There is no pipeline, so reversal is immediate.
- tc depends on the current bin_q and up only, not on en. It is valid in the same cycle.
- Width rules:
  - All arithmetic is WIDTH bits; no carry-out port.
  - RESET_GRAY and load_val are interpreted as Gray code.
  - Any WIDTH-bit value is legal.

Test Plan:
- Reset and up-count (WIDTH = 4, SATURATE = 0): rst_n low then high, en = 1, up = 1 for 16 edges -> gray_q steps 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, then 0000. The Hamming distance between successive values is 1 at every step. wrap pulses exactly once, the cycle gray_q returns to 0000. tc = 1 while gray_q = 1000.
- Down-count wrap: from reset, up = 0, en = 1 for one edge -> gray_q = 1000, bin_q = 15, wrap = 1 for one cycle. With en = 0 the counter holds and wrap = 0.
- Load priority: load_val = 1101 (bin 9), load = 1 and en = 1 on the same edge -> gray_q = 1101, bin_q = 9, no count step, wrap = 0. The next enabled up edge gives 1111 (bin 10).
- Saturate (SATURATE = 1): load 1000 (bin 15), up = 1, en = 1 for 3 edges -> gray_q stays 1000, wrap never asserts, tc = 1 throughout. Setting up = 0 gives 1001 (bin 14) on the next edge and tc = 0.
- Asynchronous reset mid-count (RESET_GRAY = 0110): assert rst_n between clock edges while counting -> gray_q = 0110 and bin_q = 4 immediately, without waiting for clk. After release, counting resumes from 4.
- Width sweep (WIDTH = 2, 8, 16): free-run up for 2^WIDTH + 1 edges -> every value is visited exactly once before the wrap, one bit changes per step, and bin_q == gray2bin(gray_q) every cycle.
